// File: rtl/seed_bank_scheduler.sv
// rtl/seed_bank_scheduler.sv - round-robin sharing of one seed LFSR bank between generator lanes
module seed_bank_scheduler #(
  parameter  int NUM_REQ        = 4,
  parameter  int SEED_COUNT     = 64,
  parameter  int DATA_WIDTH     = 16,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IW             = $clog2(SEED_COUNT),
  localparam int RW             = $clog2(NUM_REQ),
  localparam int TW             = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             bank_start,
  input  logic                             bank_done,
  input  logic [DATA_WIDTH*SEED_COUNT-1:0] bank_seed_flat,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [IW-1:0]                    out_idx,
  output logic                             out_last,
  output logic                             busy,
  output logic                             err_timeout,
  output logic [15:0]                      batch_count
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_STREAM} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [RW-1:0]        gidx_q, gidx_d;
  logic [RW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic                 bank_start_q, bank_start_d;
  logic                 out_valid_q, out_valid_d;
  logic [IW-1:0]        out_idx_q, out_idx_d;
  logic                 out_last_q, out_last_d;
  logic                 busy_q, busy_d;
  logic                 err_timeout_q, err_timeout_d;
  logic [15:0]          batch_count_q, batch_count_d;

  logic                 pick_found;
  logic [RW-1:0]        pick_idx;
  logic [RW:0]          cand;
  logic                 owner_req;
  logic [RW-1:0]        next_rr;
  logic [DATA_WIDTH-1:0] words [SEED_COUNT];

  // Bank keeps seed_flat stable until its next start, so the stream reads it directly.
  always_comb begin
    for (int i = 0; i < SEED_COUNT; i++) begin
      words[i] = bank_seed_flat[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (RW+1)'(i);
      if (cand >= (RW+1)'(NUM_REQ)) cand = cand - (RW+1)'(NUM_REQ);
      if (!pick_found && req[RW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = RW'(cand);
      end
    end
  end

  assign owner_req = |(req & grant_q);
  assign next_rr   = (gidx_q == RW'(NUM_REQ-1)) ? '0 : gidx_q + RW'(1);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_ptr_d      = rr_ptr_q;
    timer_d       = timer_q;
    bank_start_d  = 1'b0;
    out_valid_d   = out_valid_q;
    out_idx_d     = out_idx_q;
    out_last_d    = out_last_q;
    err_timeout_d = err_timeout_q;
    batch_count_d = batch_count_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = NUM_REQ'(1) << pick_idx;
          gidx_d  = pick_idx;
          state_d = S_START;
        end
      end
      S_START: begin
        bank_start_d = 1'b1;
        timer_d      = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (!owner_req) begin
          grant_d  = '0;
          rr_ptr_d = next_rr;
          state_d  = S_IDLE;
        end else if (bank_done) begin
          out_idx_d   = '0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          state_d     = S_STREAM;
        end else if (timer_q == TW'(TIMEOUT_CYCLES-1)) begin
          err_timeout_d = 1'b1;
          grant_d       = '0;
          rr_ptr_d      = next_rr;
          state_d       = S_IDLE;
        end
      end
      S_STREAM: begin
        // A dropped request aborts even when the current word would have been accepted.
        if (!owner_req || (out_ready && out_last_q)) begin
          if (owner_req) batch_count_d = batch_count_q + 16'd1;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          grant_d     = '0;
          rr_ptr_d    = next_rr;
          state_d     = S_IDLE;
        end else if (out_ready) begin
          out_idx_d  = out_idx_q + IW'(1);
          out_last_d = (out_idx_q == IW'(SEED_COUNT-2));
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      rr_ptr_q      <= '0;
      timer_q       <= '0;
      bank_start_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_idx_q     <= '0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      batch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      rr_ptr_q      <= rr_ptr_d;
      timer_q       <= timer_d;
      bank_start_q  <= bank_start_d;
      out_valid_q   <= out_valid_d;
      out_idx_q     <= out_idx_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      err_timeout_q <= err_timeout_d;
      batch_count_q <= batch_count_d;
    end
  end

  assign grant       = grant_q;
  assign bank_start  = bank_start_q;
  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign out_last    = out_last_q;
  assign out_data    = words[out_idx_q];
  assign busy        = busy_q;
  assign err_timeout = err_timeout_q;
  assign batch_count = batch_count_q;

endmodule

// File: tb/tb_seed_bank_scheduler.sv
// tb/tb_seed_bank_scheduler.sv - scoreboard bench for seed_bank_scheduler
module tb_seed_bank_scheduler;
  localparam int NR = 4;
  localparam int SC = 64;
  localparam int DW = 16;
  localparam int TO = 1024;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR-1:0]     grant;
  logic              bank_start;
  logic              bank_done = 1'b0;
  logic [DW*SC-1:0]  bank_seed_flat = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic [5:0]        out_idx;
  logic              out_last;
  logic              busy;
  logic              err_timeout;
  logic [15:0]       batch_count;

  seed_bank_scheduler #(.NUM_REQ(NR), .SEED_COUNT(SC), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant), .bank_start(bank_start),
    .bank_done(bank_done), .bank_seed_flat(bank_seed_flat), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .busy(busy), .err_timeout(err_timeout), .batch_count(batch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0] grant;
    logic [5:0]    idx;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          sb_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  logic [DW-1:0] seeds [SC];
  bit            bank_en = 1'b1;
  int            bank_lat = 4;
  int            bank_pend = 0;
  int            starts_cnt = 0;
  bit            stalled = 1'b0;
  logic [5:0]    st_idx;
  logic [DW-1:0] st_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_batch(input logic [NR-1:0] g, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.grant = g;
      e.idx   = 6'(i);
      e.data  = (i == 0) ? 16'hACE1 : (i == 1) ? 16'h59C3 : seeds[i];
      e.last  = (i == SC-1);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_grant(input string name, input logic [NR-1:0] exp);
    int n;
    n = 0;
    while (grant == '0 && n < 3000) begin
      tick();
      n++;
    end
    chk(name, grant, exp);
  endtask

  task automatic wait_idx(input logic [5:0] idx);
    int n;
    n = 0;
    while (!(out_valid && out_idx == idx) && n < 3000) begin
      tick();
      n++;
    end
    chk("reach_idx", out_idx, idx);
  endtask

  // Waits for the last-word handshake, then releases lanes once the block is back in IDLE.
  task automatic finish_batch(input logic [NR-1:0] rel, input bit toggle);
    int n;
    bit hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < 3000) begin
      if (toggle) out_ready = (n % 4 == 0) || (n % 4 == 3);
      hit = out_valid && out_ready && out_last;
      tick();
      n++;
    end
    chk("batch_completed", hit, 1);
    chk("idle_grant", grant, 0);
    chk("idle_busy", busy, 0);
    req = req & ~rel;
  endtask

  // Bank model: done pulse bank_lat cycles after each start; driven on negedge.
  initial begin
    forever begin
      @(negedge clk);
      bank_done = 1'b0;
      if (bank_pend > 0) begin
        bank_pend--;
        if (bank_pend == 0) bank_done = 1'b1;
      end
      if (bank_start && rst_n) begin
        starts_cnt++;
        if (bank_en) bank_pend = bank_lat;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid && stalled) begin
        chk("hold_idx", out_idx, st_idx);
        chk("hold_data", out_data, st_data);
      end
      stalled = out_valid && !out_ready;
      st_idx  = out_idx;
      st_data = out_data;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: idx %0d data %0h with empty scoreboard", out_idx, out_data);
        end else begin
          e = sb_q.pop_front();
          chk("sb_grant", grant, e.grant);
          chk("sb_idx", out_idx, e.idx);
          chk("sb_data", out_data, e.data);
          chk("sb_last", out_last, e.last);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0]   lfsr;
    logic [NR-1:0] t3_exp [5];
    int            n;
    int            s0;
    t3_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    lfsr = 16'hACE1;
    for (int i = 0; i < SC; i++) begin
      seeds[i] = lfsr;
      bank_seed_flat[i*DW +: DW] = lfsr;
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    tick();
    tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_start", bank_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_count", batch_count, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    rst_n = 1'b1;

    // single lane with latency checks
    out_ready = 1'b1;
    push_batch(4'b0001, SC);
    req = 4'b0001;
    tick();
    chk("t2_grant_lat", grant, 4'b0001);
    chk("t2_busy", busy, 1);
    tick();
    chk("t2_start_lat", bank_start, 1);
    tick();
    chk("t2_start_pulse", bank_start, 0);
    n = 0;
    while (!bank_done && n < 100) begin
      tick();
      n++;
    end
    chk("t2_valid_after_done", out_valid, 1);
    chk("t2_first_idx", out_idx, 0);
    finish_batch(4'b0001, 1'b0);
    chk("t2_count", batch_count, 1);
    chk("t2_starts", starts_cnt, 1);

    // reset in the middle of a stream
    push_batch(4'b0100, 21);
    req = 4'b0100;
    wait_grant("t1_grant_rr", 4'b0100);
    wait_idx(6'd20);
    rst_n = 1'b0;
    req = '0;
    tick();
    chk("t1_valid", out_valid, 0);
    chk("t1_grant", grant, 0);
    chk("t1_busy", busy, 0);
    chk("t1_count", batch_count, 0);
    chk("t1_start", bank_start, 0);
    rst_n = 1'b1;

    // round robin, all lanes requesting
    for (int b = 0; b < 5; b++) push_batch(t3_exp[b], SC);
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      wait_grant("t3_grant", t3_exp[b]);
      finish_batch((b == 4) ? 4'b1111 : 4'b0000, 1'b0);
    end
    chk("t3_count", batch_count, 5);

    // round robin over sparse requests from rr_ptr 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    push_batch(4'b0010, SC);
    push_batch(4'b1000, SC);
    req = 4'b1010;
    wait_grant("t3b_grant0", 4'b0010);
    finish_batch(4'b0000, 1'b0);
    wait_grant("t3b_grant1", 4'b1000);
    finish_batch(4'b1010, 1'b0);
    chk("t3b_count", batch_count, 2);

    // backpressure 1,0,0,1
    push_batch(4'b0001, SC);
    req = 4'b0001;
    wait_grant("t4_grant", 4'b0001);
    finish_batch(4'b0001, 1'b1);
    out_ready = 1'b1;
    chk("t4_count", batch_count, 3);

    // timeout with a dead bank, then a good batch
    bank_en = 1'b0;
    push_batch(4'b0100, SC);
    req = 4'b0110;
    wait_grant("t5_grant", 4'b0010);
    n = 0;
    while (!bank_start && n < 100) begin
      tick();
      n++;
    end
    n = 0;
    while (!err_timeout && n < 2000) begin
      tick();
      n++;
    end
    chk("t5_wait_cycles", n, TO);
    chk("t5_grant_cleared", grant, 0);
    chk("t5_idle", busy, 0);
    req = 4'b0100;
    bank_en = 1'b1;
    wait_grant("t5_next_grant", 4'b0100);
    finish_batch(4'b0100, 1'b0);
    chk("t5_err_sticky", err_timeout, 1);
    chk("t5_count", batch_count, 4);

    // abort by dropping the granted request at idx 10
    push_batch(4'b1000, 10);
    req = 4'b1001;
    wait_grant("t6_grant", 4'b1000);
    wait_idx(6'd10);
    s0 = starts_cnt;
    req = 4'b0001;
    out_ready = 1'b0;
    tick();
    chk("t6_valid", out_valid, 0);
    chk("t6_grant", grant, 0);
    chk("t6_count", batch_count, 4);
    out_ready = 1'b1;
    push_batch(4'b0001, SC);
    wait_grant("t6_next_grant", 4'b0001);
    finish_batch(4'b0001, 1'b0);
    chk("t6_fresh_start", starts_cnt, s0 + 1);
    chk("t6_count_after", batch_count, 5);

    tick();
    tick();
    chk("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
